// File: rtl/uart_tx_arb_pkg.sv
// Shared types for the UART TX byte-stream arbiter.
// Holds the arbiter state encoding and the byte width.
package uart_tx_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/uart_tx_arb_rr_sel.sv
// Round-robin pick: first requester after last_id, wrapping.
// Ports: req (per-requester request), last_id (previous grant),
//        found (any request), next_id (selected requester).
module uart_tx_arb_rr_sel
  import uart_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_id,
  output logic               found,
  output logic [GW-1:0]      next_id
);

  always_comb begin
    int idx;
    found   = 1'b0;
    next_id = last_id;
    idx     = 0;
    // Scanning from last_id+1 and ending on last_id itself lets a
    // lone requester be re-granted.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_id) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        next_id = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter feeding one UART TX byte stream.
// Ports: s_valid/s_data/s_last/s_ready (per-requester byte stream),
//        m_valid/m_data/m_ready (to UART TX serializer),
//        busy (grant held), grant_id (current/last grant),
//        timeout_pulse (grant revoked after idle timeout).
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int IDLE_TIMEOUT = 1024,
  localparam int GW           = $clog2(NUM_REQ),
  localparam int TW           = $clog2(IDLE_TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        s_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] s_data,
  input  logic [NUM_REQ-1:0]        s_last,
  output logic [NUM_REQ-1:0]        s_ready,
  output logic                      m_valid,
  output logic [BYTE_W-1:0]         m_data,
  input  logic                      m_ready,
  output logic                      busy,
  output logic [GW-1:0]             grant_id,
  output logic                      timeout_pulse
);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] gid_q, gid_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tp_q, tp_d;

  logic          g_valid;
  logic          g_last;
  logic          hs;
  logic          found;
  logic [GW-1:0] next_id;

  uart_tx_arb_rr_sel #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_sel (
    .req     (s_valid),
    .last_id (gid_q),
    .found   (found),
    .next_id (next_id)
  );

  assign g_valid = s_valid[gid_q];
  assign g_last  = s_last[gid_q];

  always_comb begin
    busy    = (state_q == ARB_GRANT);
    m_valid = busy & g_valid;
    m_data  = busy ? s_data[BYTE_W*int'(gid_q) +: BYTE_W]
                   : '0;
    s_ready = '0;
    if (busy) begin
      s_ready[gid_q] = m_ready;
    end
  end

  assign hs            = m_valid & m_ready;
  assign grant_id      = gid_q;
  assign timeout_pulse = tp_q;

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    tp_d    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d = ARB_GRANT;
          gid_d   = next_id;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (hs && g_last) begin
          state_d = ARB_IDLE;
          cnt_d   = '0;
        end else if (g_valid) begin
          // A stalled downstream never ages the grant.
          cnt_d = '0;
        end else if (cnt_q == TW'(IDLE_TIMEOUT - 1)) begin
          // grant_id kept: rotation resumes after the revoked one.
          state_d = ARB_IDLE;
          cnt_d   = '0;
          tp_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gid_q   <= GW'(NUM_REQ - 1);
      cnt_q   <= '0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      tp_q    <= tp_d;
    end
  end

endmodule
